// File: rtl/lcd_multiline_controller_if.sv
// lcd_multiline_controller_if: host text/handshake signals plus the LCD pin bundle
interface lcd_multiline_controller_if #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    logic [ROWS*COLS*8-1:0] text;
    logic                   update;
    logic                   busy;
    logic                   frame_done;
    logic                   lcd_rs;
    logic                   lcd_rw;
    logic                   lcd_e;
    logic [7:0]             lcd_data;
    modport master (output text, update, input busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd_data);
    modport slave (input text, update, output busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_multiline_controller.sv
// lcd_multiline_controller: HD44780-style driver that inits the panel, then rewrites all
// ROWS x COLS characters from a snapshot of the text bus on each update request.
module lcd_multiline_controller #(
    parameter int ROWS            = 2,
    parameter int COLS            = 16,
    parameter int E_PULSE         = 25,
    parameter int CMD_DELAY       = 50000,
    parameter int CLR_DELAY       = 100000,
    parameter int PWR_DELAY       = 750000,
    parameter bit CLEAR_ON_UPDATE = 1'b0
) (
    input logic                       clk,
    input logic                       rst,
    lcd_multiline_controller_if.slave bus
);
    localparam int M1   = CMD_DELAY > CLR_DELAY ? CMD_DELAY : CLR_DELAY;
    localparam int M2   = M1 > PWR_DELAY ? M1 : PWR_DELAY;
    localparam int MAXD = M2 > E_PULSE ? M2 : E_PULSE;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int KW   = COLS > 1 ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_DELAY - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_DELAY - 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_DELAY - 1);
    localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
    localparam logic [KW-1:0] C_LAST   = KW'(COLS - 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CLR, ADDR, CHAR, DONE} state_t;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

    state_t                 state, state_n;
    phase_t                 phase, phase_n;
    logic [CW-1:0]          cnt, cnt_n, d_last;
    logic [1:0]             init_idx, init_n, r2;
    logic [RW-1:0]          r, r_n;
    logic [KW-1:0]          c, c_n;
    logic                   pending, pend_n, xfer, start;
    logic [ROWS*COLS*8-1:0] snap, snap_n;
    logic [7:0]             cur;
    int                     idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PWR_WAIT;
            phase    <= P_SETUP;
            cnt      <= '0;
            init_idx <= '0;
            r        <= '0;
            c        <= '0;
            pending  <= 1'b0;
            snap     <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            cnt      <= cnt_n;
            init_idx <= init_n;
            r        <= r_n;
            c        <= c_n;
            pending  <= pend_n;
            snap     <= snap_n;
        end
    end

    always_comb begin
        r2      = 2'(r);
        idx     = int'(r) * COLS + int'(c);
        cur     = state == CHAR ? snap[idx*8 +: 8] :
                  state == ADDR ? (r2 == 2'd0 ? 8'h80 : r2 == 2'd1 ? 8'hC0 : r2 == 2'd2 ? 8'h94 : 8'hD4) :
                  state == CLR  ? 8'h01 :
                  init_idx == 2'd0 ? 8'h38 : init_idx == 2'd1 ? 8'h0C : init_idx == 2'd2 ? 8'h06 : 8'h01;
        xfer    = state inside {INIT, CLR, ADDR, CHAR};
        // only a clear command earns the long wait; a 0x01 character does not
        d_last  = (state != CHAR && cur == 8'h01) ? CLR_LAST : CMD_LAST;
        start   = (state == IDLE || state == DONE) && (bus.update || pending);
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        init_n  = init_idx;
        r_n     = r;
        c_n     = c;
        snap_n  = snap;
        pend_n  = start ? 1'b0 : (bus.update && state != IDLE) ? 1'b1 : pending;
        if (start) begin
            snap_n  = bus.text;
            r_n     = '0;
            c_n     = '0;
            phase_n = P_SETUP;
            cnt_n   = '0;
            state_n = CLEAR_ON_UPDATE ? CLR : ADDR;
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (state == PWR_WAIT) begin
            cnt_n   = cnt == PWR_LAST ? '0 : cnt + 1'b1;
            state_n = cnt == PWR_LAST ? INIT : PWR_WAIT;
            phase_n = P_SETUP;
            init_n  = '0;
        end else if (xfer) begin
            if (phase == P_SETUP) begin
                phase_n = P_PULSE;
                cnt_n   = '0;
            end else if (phase == P_PULSE) begin
                phase_n = cnt == E_LAST ? P_WAIT : P_PULSE;
                cnt_n   = cnt == E_LAST ? '0 : cnt + 1'b1;
            end else if (cnt != d_last) begin
                cnt_n = cnt + 1'b1;
            end else begin
                cnt_n   = '0;
                phase_n = P_SETUP;
                if (state == INIT) begin
                    init_n  = init_idx + 1'b1;
                    state_n = init_idx == 2'd3 ? IDLE : INIT;
                end else if (state == CLR) begin
                    state_n = ADDR;
                end else if (state == ADDR) begin
                    c_n     = '0;
                    state_n = CHAR;
                end else begin
                    c_n     = c == C_LAST ? '0 : c + 1'b1;
                    r_n     = (c == C_LAST && r != R_LAST) ? r + 1'b1 : r;
                    state_n = c != C_LAST ? CHAR : r == R_LAST ? DONE : ADDR;
                end
            end
        end
    end

    assign bus.lcd_e      = xfer && phase == P_PULSE;
    assign bus.lcd_rs     = state == CHAR;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = xfer ? cur : 8'h00;
    assign bus.busy       = state != IDLE;
    assign bus.frame_done = state == DONE;
endmodule
